// File: rtl/stat_graph_render.sv
// Scrolling event-tally graph overlay: counts per-channel strobes over sample periods,
// keeps a ring of recent samples and draws them as auto-scaled points over a pair of axes.
module stat_graph_render #(
  parameter int                   NUM_CH        = 2,
  parameter int                   HISTORY_LEN   = 25,
  parameter int                   GRAPH_WIDTH   = 200,
  parameter int                   GRAPH_HEIGHT  = 200,
  parameter int                   ORIGIN_X      = 800,
  parameter int                   ORIGIN_Y      = 32,
  parameter int                   SAMPLE_PERIOD = 32,
  parameter int                   COUNT_W       = 16,
  parameter int                   ACTIVE_W      = 1024,
  parameter int                   ACTIVE_H      = 768,
  parameter logic [11:0]          AXIS_COLOR    = 12'hFFF,
  parameter logic [NUM_CH*12-1:0] CH_COLOR      = {12'h0F0, 12'hF00}
) (
  input  logic              clk_130mhz,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              freeze_in,
  input  logic              clear_in,
  output logic [11:0]       pix_out,
  output logic              sample_out
);
  localparam int SAMPLE_PIX = GRAPH_WIDTH / HISTORY_LEN;
  localparam int PIX_SH     = $clog2(SAMPLE_PIX);
  localparam int FC_W       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int PTR_W      = (HISTORY_LEN > 1) ? $clog2(HISTORY_LEN) : 1;
  localparam int FILL_W     = $clog2(HISTORY_LEN + 1);
  localparam int SH_W       = $clog2(COUNT_W + 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  generate
    if ((GRAPH_WIDTH % HISTORY_LEN) != 0 || SAMPLE_PIX < 1 ||
        (SAMPLE_PIX & (SAMPLE_PIX - 1)) != 0) begin : g_bad_width
      $error("GRAPH_WIDTH/HISTORY_LEN must be an integer power of two");
    end
    if (SAMPLE_PERIOD < 1 || SAMPLE_PERIOD > 256) begin : g_bad_period
      $error("SAMPLE_PERIOD must be within 1..256");
    end
  endgenerate

  logic [FC_W-1:0]    frame_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]  fill;
  logic [COUNT_W-1:0] acc        [NUM_CH];
  logic [SH_W-1:0]    shift      [NUM_CH];
  logic [COUNT_W-1:0] ring       [NUM_CH][HISTORY_LEN];
  logic [COUNT_W-1:0] value      [NUM_CH];
  logic [SH_W-1:0]    next_shift [NUM_CH];

  logic [31:0] hc, vc;
  logic        frame_end, tally_en, period_start, commit;

  assign hc           = 32'(hcount_in);
  assign vc           = 32'(vcount_in);
  assign frame_end    = (hc == ACTIVE_W - 1) && (vc == ACTIVE_H - 1);
  assign period_start = (frame_cnt == '0);
  assign tally_en     = period_start && (hc < ACTIVE_W) && (vc < ACTIVE_H);
  assign commit       = frame_end && period_start && !freeze_in;

  // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
  always_comb begin
    logic [SH_W-1:0] need;
    for (int c = 0; c < NUM_CH; c++) begin
      value[c] = acc[c];
      if (tally_en && event_in[c] && acc[c] != COUNT_MAX) value[c] = acc[c] + COUNT_W'(1);
      // Smallest shift that brings this sample under the graph height.
      need = SH_W'(COUNT_W);
      for (int s = COUNT_W; s >= 0; s--)
        if ((32'(value[c]) >> s) < 32'(GRAPH_HEIGHT)) need = SH_W'(s);
      next_shift[c] = (need > shift[c]) ? need : shift[c];
    end
  end

  // NOTE: the ring is held in flops, not RAM, because reset and clear must zero every slot at once.
  always_ff @(posedge clk_130mhz or posedge rst_in) begin
    if (rst_in) begin
      frame_cnt  <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      sample_out <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]   <= '0;
        shift[c] <= '0;
        for (int i = 0; i < HISTORY_LEN; i++) ring[c][i] <= '0;
      end
    end else if (clear_in) begin
      frame_cnt  <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      sample_out <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]   <= '0;
        shift[c] <= '0;
        for (int i = 0; i < HISTORY_LEN; i++) ring[c][i] <= '0;
      end
    end else begin
      sample_out <= commit;
      if (frame_end)
        frame_cnt <= (32'(frame_cnt) == SAMPLE_PERIOD - 1) ? '0 : frame_cnt + FC_W'(1);
      if (commit) begin
        wr_ptr <= (32'(wr_ptr) == HISTORY_LEN - 1) ? '0 : wr_ptr + PTR_W'(1);
        if (32'(fill) < HISTORY_LEN) fill <= fill + FILL_W'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (period_start) acc[c] <= frame_end ? '0 : value[c];
        if (commit) begin
          ring[c][wr_ptr] <= value[c];
          shift[c]        <= next_shift[c];
        end
      end
    end
  end

  // Read stage: map the pixel column to a history slot, oldest sample on the left.
  logic [31:0]      col, idx, slot_sum;
  logic             in_col, plot_en, on_axis;
  logic [PTR_W-1:0] rd_slot;

  always_comb begin
    in_col   = (hc > ORIGIN_X) && (hc < ORIGIN_X + GRAPH_WIDTH);
    col      = hc - 32'(ORIGIN_X) - 32'd1;
    idx      = col >> PIX_SH;
    plot_en  = in_col && (idx < 32'(fill));
    slot_sum = 32'(wr_ptr) + idx;
    rd_slot  = '0;
    if (plot_en) begin
      if (32'(fill) < HISTORY_LEN)      rd_slot = PTR_W'(idx);
      else if (slot_sum >= HISTORY_LEN) rd_slot = PTR_W'(slot_sum - HISTORY_LEN);
      else                              rd_slot = PTR_W'(slot_sum);
    end
  end

  assign on_axis = ((vc == ORIGIN_Y + GRAPH_HEIGHT) && (hc >= ORIGIN_X) && (hc <= ORIGIN_X + GRAPH_WIDTH)) ||
                   ((hc == ORIGIN_X) && (vc >= ORIGIN_Y) && (vc <= ORIGIN_Y + GRAPH_HEIGHT));

  logic [COUNT_W-1:0] s1_height [NUM_CH];
  logic               s1_plot, s1_axis;
  logic [9:0]         s1_vcount;
  logic [11:0]        pix_next;

  // Compare/colour stage: lowest channel index wins when points overlap.
  always_comb begin
    pix_next = '0;
    if (s1_axis) begin
      pix_next = AXIS_COLOR;
    end else if (s1_plot) begin
      for (int c = NUM_CH - 1; c >= 0; c--)
        if ((32'(s1_vcount) == 32'(ORIGIN_Y + GRAPH_HEIGHT - 1) - 32'(s1_height[c])) &&
            (32'(s1_vcount) > ORIGIN_Y))
          pix_next = CH_COLOR[c*12 +: 12];
    end
  end

  always_ff @(posedge clk_130mhz or posedge rst_in) begin
    if (rst_in) begin
      s1_plot   <= 1'b0;
      s1_axis   <= 1'b0;
      s1_vcount <= '0;
      pix_out   <= '0;
      for (int c = 0; c < NUM_CH; c++) s1_height[c] <= '0;
    end else begin
      s1_plot   <= plot_en;
      s1_axis   <= on_axis;
      s1_vcount <= vcount_in;
      pix_out   <= pix_next;
      for (int c = 0; c < NUM_CH; c++) s1_height[c] <= ring[c][rd_slot] >> shift[c];
    end
  end

endmodule

// File: tb/tb_stat_graph_render.sv
// Self-checking bench for stat_graph_render: drives pixel coordinates directly and compares
// pix_out/sample_out every cycle against a queue-based model of the sample history.
module tb_stat_graph_render;
  localparam int NUM_CH = 2;
  localparam int HL     = 25;
  localparam int GW     = 200;
  localparam int GH     = 200;
  localparam int OX     = 800;
  localparam int OY     = 32;
  localparam int SP     = 3;
  localparam int CW     = 12;
  localparam int AW     = 1024;
  localparam int AH     = 768;
  localparam int MAXV   = (1 << CW) - 1;
  localparam int IDLE_H = 1100;
  localparam int IDLE_V = 800;
  localparam logic [11:0] AXIS = 12'hFFF;
  localparam logic [11:0] COL0 = 12'hF00;
  localparam logic [11:0] COL1 = 12'h0F0;

  logic              clk_130mhz = 1'b0;
  logic              rst_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [NUM_CH-1:0] event_in;
  logic              freeze_in;
  logic              clear_in;
  logic [11:0]       pix_out;
  logic              sample_out;

  always #5 clk_130mhz = ~clk_130mhz;

  stat_graph_render #(
    .NUM_CH(NUM_CH), .HISTORY_LEN(HL), .GRAPH_WIDTH(GW), .GRAPH_HEIGHT(GH),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .SAMPLE_PERIOD(SP), .COUNT_W(CW),
    .ACTIVE_W(AW), .ACTIVE_H(AH), .AXIS_COLOR(AXIS), .CH_COLOR({COL1, COL0})
  ) dut (
    .clk_130mhz(clk_130mhz),
    .rst_in(rst_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .event_in(event_in),
    .freeze_in(freeze_in),
    .clear_in(clear_in),
    .pix_out(pix_out),
    .sample_out(sample_out)
  );

  int          checks = 0;
  int          failures = 0;
  int          m_acc [NUM_CH];
  int          m_shift [NUM_CH];
  int          m_fc;
  int          hist0 [$];
  int          hist1 [$];
  logic [11:0] exp_d1;
  string       d1_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_acc   = '{0, 0};
    m_shift = '{0, 0};
    m_fc    = 0;
    hist0.delete();
    hist1.delete();
  endfunction

  function automatic int hist_val(input int c, input int idx);
    return (c == 0) ? hist0[idx] : hist1[idx];
  endfunction

  // Expected colour for a pixel given the current history (oldest sample leftmost).
  function automatic logic [11:0] model_pix(input int h, input int v);
    if ((v == OY + GH && h >= OX && h <= OX + GW) || (h == OX && v >= OY && v <= OY + GH))
      return AXIS;
    if (h > OX && h < OX + GW) begin
      int idx = (h - OX - 1) / (GW / HL);
      if (idx < hist0.size()) begin
        for (int c = 0; c < NUM_CH; c++) begin
          int ht = hist_val(c, idx) >> m_shift[c];
          if (v == OY + GH - 1 - ht && v > OY) return (c == 0) ? COL0 : COL1;
        end
      end
    end
    return 12'h000;
  endfunction

  // Applies one cycle of inputs to the model; returns whether a sample is committed.
  function automatic bit model_update(input int h, input int v, input logic [1:0] ev,
                                      input logic frz, input logic clr);
    int val [NUM_CH];
    bit done = 1'b0;
    if (clr) begin
      model_reset();
      return 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      val[c] = m_acc[c];
      if (m_fc == 0 && h < AW && v < AH && ev[c] && val[c] < MAXV) val[c]++;
      if (m_fc == 0) m_acc[c] = val[c];
    end
    if (h == AW - 1 && v == AH - 1) begin
      if (m_fc == 0) begin
        m_acc = '{0, 0};
        if (!frz) begin
          hist0.push_back(val[0]);
          hist1.push_back(val[1]);
          if (hist0.size() > HL) begin
            void'(hist0.pop_front());
            void'(hist1.pop_front());
          end
          for (int c = 0; c < NUM_CH; c++)
            while ((val[c] >> m_shift[c]) >= GH) m_shift[c]++;
          done = 1'b1;
        end
      end
      m_fc = (m_fc + 1) % SP;
    end
    return done;
  endfunction

  task automatic step(input int h, input int v, input logic [1:0] ev,
                      input logic frz, input logic clr);
    logic [11:0] p;
    bit          done;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    event_in  = ev;
    freeze_in = frz;
    clear_in  = clr;
    p    = model_pix(h, v);
    done = model_update(h, v, ev, frz, clr);
    @(posedge clk_130mhz);
    #1;
    check(d1_tag, pix_out, exp_d1);
    check("sample_out", sample_out, done);
    exp_d1 = p;
    d1_tag = $sformatf("pix(%0d,%0d)", h, v);
  endtask

  task automatic idle_step();
    step(IDLE_H, IDLE_V, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic peek(input int h, input int v, input logic [11:0] exp, input string tag);
    step(h, v, 2'b00, 1'b0, 1'b0);
    idle_step();
    check(tag, pix_out, exp);
  endtask

  task automatic ev_steps(input int n, input logic [1:0] ev);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, AW - 2), $urandom_range(0, AH - 1), ev, 1'b0, 1'b0);
  endtask

  task automatic frame_end_step(input logic frz);
    step(AW - 1, AH - 1, 2'b00, frz, 1'b0);
  endtask

  task automatic finish_period();
    while (m_fc != 0) frame_end_step(1'b0);
  endtask

  task automatic commit_sample(input int n, input logic [1:0] ev);
    finish_period();
    ev_steps(n, ev);
    frame_end_step(1'b0);
  endtask

  // Probes the expected point of every plotted sample and the rows either side of it.
  task automatic probe_points();
    int n = hist0.size();
    for (int idx = 0; idx < n; idx++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int row = OY + GH - 1 - (hist_val(c, idx) >> m_shift[c]);
        int h   = OX + 1 + idx * (GW / HL) + int'($urandom_range(0, 6));
        for (int d = -1; d <= 1; d++) step(h, row + d, 2'b00, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    int lit_h, lit_row;

    rst_in    = 1'b1;
    hcount_in = 11'(IDLE_H);
    vcount_in = 10'(IDLE_V);
    event_in  = '0;
    freeze_in = 1'b0;
    clear_in  = 1'b0;
    repeat (3) @(posedge clk_130mhz);
    #1;
    check("reset_pix", pix_out, 12'h000);
    check("reset_sample", sample_out, 1'b0);
    rst_in = 1'b0;
    model_reset();
    exp_d1 = '0;
    d1_tag = "pix_after_reset";
    idle_step();

    // 150 ch0 events in the first sample frame.
    ev_steps(150, 2'b01);
    frame_end_step(1'b0);
    check("commit150_pulse", sample_out, 1'b1);
    peek(OX + 1, 81, COL0, "commit150_point");
    peek(OX + 1, OY + GH - 1, COL1, "ch1_zero_point");

    // Saturation: 4095 fits with shift 5, plotted at height 127.
    commit_sample(MAXV + 5, 2'b01);
    peek(OX + 9, 104, COL0, "saturated_point");
    peek(OX + 1, 227, COL0, "rescaled_old_point");

    // Clear wipes history, shifts and ring.
    step(IDLE_H, IDLE_V, 2'b00, 1'b0, 1'b1);
    peek(OX + 9, 104, 12'h000, "cleared_point");

    // 26 samples 1..26 into a 25-deep history.
    for (int k = 1; k <= 26; k++) commit_sample(k, 2'b01);
    peek(OX + 1, 229, COL0, "wrap_oldest");
    peek(OX + 1 + 24 * (GW / HL), 205, COL0, "wrap_newest");

    // Frozen sample frame: no pulse, history untouched, tally restarts.
    finish_period();
    ev_steps(20, 2'b01);
    frame_end_step(1'b1);
    check("freeze_no_pulse", sample_out, 1'b0);
    peek(OX + 1, 229, COL0, "freeze_history_kept");
    commit_sample(5, 2'b01);
    peek(OX + 1 + 24 * (GW / HL), 226, COL0, "post_freeze_value");
    peek(OX + 1, 228, COL0, "post_freeze_oldest");

    // Equal heights on both channels, then axis latency.
    step(IDLE_H, IDLE_V, 2'b00, 1'b0, 1'b1);
    commit_sample(10, 2'b11);
    peek(OX + 1, 221, COL0, "overlap_priority");
    step(OX, OY + GH, 2'b00, 1'b0, 1'b0);
    check("axis_lag1", pix_out, 12'h000);
    idle_step();
    check("axis_lag2", pix_out, AXIS);

    // Randomized traffic across the graph area and the rest of the frame.
    for (int i = 0; i < 1500; i++) begin
      int r = int'($urandom_range(0, 399));
      if (r < 16)
        step(AW - 1, AH - 1, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
      else if (r == 16)
        step(IDLE_H, IDLE_V, 2'b00, 1'b0, 1'b1);
      else if (r < 300)
        step($urandom_range(OX - 3, OX + GW + 3), $urandom_range(OY - 4, OY + GH + 4),
             2'($urandom_range(0, 3)), 1'b0, 1'b0);
      else
        step($urandom_range(0, AW - 2), $urandom_range(0, AH - 1),
             2'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
    probe_points();

    // Reset pulse three cycles into a sample frame.
    commit_sample(40, 2'b01);
    lit_h   = OX + 1 + (hist0.size() - 1) * (GW / HL);
    lit_row = OY + GH - 1 - (40 >> m_shift[0]);
    peek(lit_h, lit_row, COL0, "pre_reset_point");
    finish_period();
    for (int i = 0; i < 3; i++) step(OX, 100, 2'b01, 1'b0, 1'b0);
    #2 rst_in = 1'b1;
    #1;
    check("async_reset_pix", pix_out, 12'h000);
    check("async_reset_sample", sample_out, 1'b0);
    @(posedge clk_130mhz);
    #1;
    check("reset_hold_pix", pix_out, 12'h000);
    rst_in = 1'b0;
    model_reset();
    exp_d1 = '0;
    d1_tag = "pix_after_midframe_reset";
    peek(lit_h, lit_row, 12'h000, "post_reset_point");
    ev_steps(7, 2'b01);
    frame_end_step(1'b0);
    check("first_commit_after_reset", sample_out, 1'b1);
    peek(OX + 1, 224, COL0, "post_reset_sample");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
